song_play_ctrl: RTL and testbench

//  Playback sequencer for the buzzer datapath. It walks a synchronous note ROM
//  (note code + duration + last-note flag per entry) for the selected song.
//  It times each note in beat units, inserts a silent gap between notes, and

---
 rtl/song_play_ctrl.sv | 156 +++++++++++++++
 tb/tb_song_play_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/song_play_ctrl.sv
// rtl/song_play_ctrl.sv - note ROM playback sequencer with beat/gap timing, pause/skip/stop and loop
module song_play_ctrl #(
    parameter int BEAT_CYCLES = 500000,
    parameter int GAP_CYCLES  = 50000,
    parameter int SONG_W      = 2,
    parameter int ADDR_W      = 5,
    parameter int NOTE_W      = 4,
    parameter int DUR_W       = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SONG_W-1:0]        song_select,
    input  logic                     play,
    input  logic                     pause,
    input  logic                     stop,
    input  logic                     skip,
    input  logic                     loop_en,
    output logic [SONG_W+ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0]        rom_note,
    input  logic [DUR_W-1:0]         rom_dur,
    input  logic                     rom_last,
    output logic [NOTE_W-1:0]        note_to_play,
    output logic                     note_valid,
    output logic                     playing,
    output logic                     paused,
    output logic                     song_done
);
    localparam int PLAY_MAX = BEAT_CYCLES * ((1 << DUR_W) - 1);
    localparam int CNT_MAX  = (PLAY_MAX > GAP_CYCLES) ? PLAY_MAX : GAP_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BEAT_C   = CNT_W'(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_SKIP, S_PAUSE
    } state_t;

    state_t                     state_q, saved_q;
    logic [SONG_W-1:0]          song_q;
    logic [ADDR_W-1:0]          idx_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [NOTE_W-1:0]          note_q;
    logic [DUR_W-1:0]           dur_q;
    logic                       last_q;
    logic [SONG_W+ADDR_W-1:0]   rom_addr_q;
    logic [NOTE_W-1:0]          note_out_q;
    logic                       valid_q, playing_q, paused_q, done_q;

    logic [CNT_W-1:0]           play_last_d;
    logic                       is_last_d, end_note_d;
    logic [ADDR_W-1:0]          idx_next_d;

    assign play_last_d = CNT_W'(dur_q) * BEAT_C - CNT_W'(1);
    assign is_last_d   = last_q || (idx_q == '1);
    assign idx_next_d  = is_last_d ? '0 : idx_q + ADDR_W'(1);
    assign end_note_d  = (state_q == S_SKIP) ||
                         (state_q == S_GAP && cnt_q == GAP_LAST && !pause && !skip);

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            state_q    <= S_IDLE;
            saved_q    <= S_IDLE;
            song_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            last_q     <= 1'b0;
            rom_addr_q <= '0;
            note_out_q <= '0;
            valid_q    <= 1'b0;
            playing_q  <= 1'b0;
            paused_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (play) begin
                    song_q     <= song_select;
                    idx_q      <= '0;
                    rom_addr_q <= {song_select, ADDR_W'(0)};
                    playing_q  <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_FETCH: state_q <= S_LOAD;
                S_LOAD: begin
                    note_q     <= rom_note;
                    dur_q      <= (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                    last_q     <= rom_last;
                    note_out_q <= rom_note;
                    valid_q    <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= S_PLAY;
                end
                S_PLAY, S_GAP: begin
                    if (pause) begin
                        // The cycle that sees pause still counts as elapsed time.
                        if (state_q == S_PLAY) begin
                            saved_q <= (cnt_q == play_last_d) ? S_GAP : S_PLAY;
                            cnt_q   <= (cnt_q == play_last_d) ? '0 : cnt_q + CNT_W'(1);
                        end else begin
                            saved_q <= (cnt_q == GAP_LAST) ? S_SKIP : S_GAP;
                            cnt_q   <= (cnt_q == GAP_LAST) ? '0 : cnt_q + CNT_W'(1);
                        end
                        note_out_q <= '0;
                        valid_q    <= 1'b0;
                        playing_q  <= 1'b0;
                        paused_q   <= 1'b1;
                        state_q    <= S_PAUSE;
                    end else if (skip) begin
                        cnt_q      <= '0;
                        note_out_q <= '0;
                        valid_q    <= 1'b0;
                        state_q    <= S_SKIP;
                    end else if (state_q == S_PLAY && cnt_q == play_last_d) begin
                        cnt_q      <= '0;
                        note_out_q <= '0;
                        valid_q    <= 1'b0;
                        state_q    <= S_GAP;
                    end else if (!end_note_d) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PAUSE: if (play) begin
                    state_q   <= saved_q;
                    paused_q  <= 1'b0;
                    playing_q <= 1'b1;
                    if (saved_q == S_PLAY) begin
                        note_out_q <= note_q;
                        valid_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (end_note_d) begin
                cnt_q <= '0;
                if (is_last_d && !loop_en) begin
                    done_q    <= 1'b1;
                    playing_q <= 1'b0;
                    state_q   <= S_IDLE;
                end else begin
                    idx_q      <= idx_next_d;
                    rom_addr_q <= {song_q, idx_next_d};
                    state_q    <= S_FETCH;
                end
            end
        end
    end

    assign rom_addr     = rom_addr_q;
    assign note_to_play = note_out_q;
    assign note_valid   = valid_q;
    assign playing      = playing_q;
    assign paused       = paused_q;
    assign song_done    = done_q;
endmodule

// File: tb/tb_song_play_ctrl.sv
// tb/tb_song_play_ctrl.sv - directed table and sequence checks for song_play_ctrl
module tb_song_play_ctrl;
    logic       clk = 1'b0;
    logic       rst, play, pause, stop, skip, loop_en;
    logic [1:0] song_select;
    logic [6:0] rom_addr;
    logic [3:0] rom_note;
    logic [2:0] rom_dur;
    logic       rom_last;
    logic [3:0] note_to_play;
    logic       note_valid, playing, paused, song_done;

    always #5 clk = ~clk;

    song_play_ctrl #(
        .BEAT_CYCLES(4), .GAP_CYCLES(2), .SONG_W(2), .ADDR_W(5), .NOTE_W(4), .DUR_W(3)
    ) dut (
        .clk(clk), .rst(rst), .song_select(song_select), .play(play), .pause(pause),
        .stop(stop), .skip(skip), .loop_en(loop_en), .rom_addr(rom_addr),
        .rom_note(rom_note), .rom_dur(rom_dur), .rom_last(rom_last),
        .note_to_play(note_to_play), .note_valid(note_valid), .playing(playing),
        .paused(paused), .song_done(song_done)
    );

    // Synchronous note ROM: {note, dur, last}
    logic [7:0] mem [0:127];
    always @(posedge clk) {rom_note, rom_dur, rom_last} <= mem[rom_addr];

    typedef struct {
        string      name;
        logic       rst;
        logic       play;
        logic [6:0] addr;
        logic [3:0] note;
        logic       valid;
        logic       playing;
        logic       paused;
        logic       done;
    } vec_t;
    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void add(string nm, logic r, logic p, logic [6:0] a, logic [3:0] n,
                                logic v, logic pl, logic ps, logic d);
        vec_t e;
        e.name = nm; e.rst = r; e.play = p; e.addr = a; e.note = n;
        e.valid = v; e.playing = pl; e.paused = ps; e.done = d;
        vecs.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {rom_addr, note_to_play, note_valid, playing, paused, song_done};
    endfunction

    task automatic start(logic [1:0] sel);
        song_select = sel;
        play = 1'b1;
        step();
        play = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        logic ok;
        rst = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; skip = 1'b0;
        loop_en = 1'b0; song_select = 2'd1;
        for (int i = 0; i < 128; i++) mem[i] = 8'h0;
        mem[7'h20] = {4'd5, 3'd2, 1'b0};
        mem[7'h21] = {4'd7, 3'd1, 1'b0};
        mem[7'h22] = {4'd3, 3'd0, 1'b1};
        for (int i = 0; i < 32; i++) mem[7'h40 + i] = {4'd9, 3'd1, 1'b0};
        for (int i = 0; i < 5; i++) mem[7'h60 + i] = {4'(i + 1), 3'd2, (i == 4)};

        add("reset", 1, 0, 7'h00, 0, 0, 0, 0, 0);
        add("fetch0", 0, 1, 7'h20, 0, 0, 1, 0, 0);
        add("load0", 0, 0, 7'h20, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) add("play0", 0, 0, 7'h20, 5, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) add("gap0", 0, 0, 7'h20, 0, 0, 1, 0, 0);
        add("fetch1", 0, 0, 7'h21, 0, 0, 1, 0, 0);
        add("load1", 0, 0, 7'h21, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add("play1", 0, 0, 7'h21, 7, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) add("gap1", 0, 0, 7'h21, 0, 0, 1, 0, 0);
        add("fetch2", 0, 0, 7'h22, 0, 0, 1, 0, 0);
        add("load2", 0, 0, 7'h22, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add("play2_dur0", 0, 0, 7'h22, 3, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) add("gap2", 0, 0, 7'h22, 0, 0, 1, 0, 0);
        add("done", 0, 0, 7'h22, 0, 0, 0, 0, 1);
        add("idle", 0, 0, 7'h22, 0, 0, 0, 0, 0);

        step();
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            play = vecs[i].play;
            step();
            rst = 1'b0;
            play = 1'b0;
            check($sformatf("%s[%0d]", vecs[i].name, i), 32'(outs()),
                  32'({vecs[i].addr, vecs[i].note, vecs[i].valid, vecs[i].playing,
                       vecs[i].paused, vecs[i].done}));
        end

        // Loop enabled: after the last note the song restarts, no done pulse
        loop_en = 1'b1;
        start(2'd1);
        seen = 0;
        for (int i = 0; i < 28; i++) begin
            step();
            if (song_done) seen++;
        end
        check("loop_addr", 32'(rom_addr), 32'h20);
        check("loop_playing", 32'(playing), 32'h1);
        check("loop_no_done", 32'(seen), 32'h0);
        loop_en = 1'b0;
        do_stop();
        check("stop_after_loop", 32'(outs()), 32'h0);

        // Pause three cycles into an 8-cycle note, resume, 5 cycles remain
        start(2'd1);
        for (int i = 0; i < 4; i++) step();
        check("pre_pause_note", 32'({note_to_play, note_valid}), 32'({4'd5, 1'b1}));
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("pause_outs", 32'({note_to_play, note_valid, playing, paused}), 32'({4'd0, 3'b001}));
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!paused || note_to_play != 0 || note_valid) ok = 1'b0;
        end
        check("pause_hold", 32'(ok), 32'h1);
        play = 1'b1;
        step();
        play = 1'b0;
        n = 0;
        while (note_to_play == 4'd5 && note_valid && n < 20) begin
            n++;
            step();
        end
        check("resume_remaining", 32'(n), 32'd5);
        check("resume_then_gap", 32'({note_valid, playing}), 32'({1'b0, 1'b1}));
        do_stop();

        // Stop and play together mid-note: stop wins
        start(2'd1);
        for (int i = 0; i < 4; i++) step();
        stop = 1'b1; play = 1'b1;
        step();
        stop = 1'b0; play = 1'b0;
        check("stop_play_same", 32'(outs()), 32'h0);
        step();
        check("stop_stays_idle", 32'(outs()), 32'h0);

        // song_select changes mid-song are ignored
        start(2'd1);
        song_select = 2'd2;
        for (int i = 0; i < 12; i++) step();
        check("sel_ignored", 32'(rom_addr), 32'h21);
        do_stop();

        // 32 non-last entries: index wrap ends the song
        start(2'd2);
        n = 0;
        while (!song_done && n < 400) begin
            step();
            n++;
        end
        check("wrap_done_cycles", 32'(n), 32'd256);
        check("wrap_last_addr", 32'(rom_addr), 32'h5f);
        step();
        check("wrap_done_pulse", 32'({song_done, playing}), 32'h0);

        // Skip during PLAY of idx 3
        start(2'd3);
        n = 0;
        while (!(rom_addr == 7'h63 && note_to_play == 4'd4) && n < 200) begin
            step();
            n++;
        end
        check("skip_reach_idx3", 32'(n < 200), 32'h1);
        step(); step();
        skip = 1'b1;
        step();
        skip = 1'b0;
        check("skip_silent", 32'({rom_addr, note_to_play, note_valid}), 32'({7'h63, 4'd0, 1'b0}));
        step();
        check("skip_next_addr", 32'({rom_addr, playing}), 32'({7'h64, 1'b1}));
        do_stop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
